// File: rtl/wb_scoreboard_pkg.sv
// rtl/wb_scoreboard_pkg.sv - shared constants for the writeback/scoreboard slice
package wb_pkg;

  localparam logic [1:0] LS_B = 2'd0;
  localparam logic [1:0] LS_H = 2'd1;
  localparam logic [1:0] LS_W = 2'd2;

  // Output stage values after reset; the address is truncated to ADDR_WIDTH at use.
  localparam logic        WB_RST_V    = 1'b0;
  localparam logic [31:0] WB_RST_ADDR = 32'd0;
  localparam logic [31:0] WB_RST_DATA = 32'd0;

endpackage

// File: rtl/wb_scoreboard_if.sv
// rtl/wb_scoreboard_if.sv - issue, EXU/LSU result, regfile write and status bundle
// Optional difftest commit ports exist only when WB_DIFFTEST_EN is defined.
interface wb_scoreboard_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                     iss_valid;
  logic [ADDR_WIDTH-1:0]    iss_rd;
  logic                     exu_valid;
  logic                     exu_ready;
  logic [ADDR_WIDTH-1:0]    exu_rd;
  logic                     exu_wen;
  logic [DATA_WIDTH-1:0]    exu_data;
  logic                     lsu_valid;
  logic                     lsu_ready;
  logic [ADDR_WIDTH-1:0]    lsu_rd;
  logic                     lsu_wen;
  logic [DATA_WIDTH-1:0]    lsu_rdata;
  logic [1:0]               lsu_size;
  logic                     lsu_unsigned;
  logic                     rf_wen;
  logic [ADDR_WIDTH-1:0]    rf_waddr;
  logic [DATA_WIDTH-1:0]    rf_wdata;
  logic [2**ADDR_WIDTH-1:0] busy_mask;
  logic [63:0]              instret;
`ifdef WB_DIFFTEST_EN
  logic [31:0]              exu_pc;
  logic [31:0]              lsu_pc;
  logic                     commit_valid;
  logic [31:0]              commit_pc;
`endif

  modport master (
    output iss_valid, iss_rd,
    output exu_valid, exu_rd, exu_wen, exu_data,
    output lsu_valid, lsu_rd, lsu_wen, lsu_rdata, lsu_size, lsu_unsigned,
    input  exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, busy_mask, instret
`ifdef WB_DIFFTEST_EN
    , output exu_pc, lsu_pc
    , input  commit_valid, commit_pc
`endif
  );

  modport slave (
    input  iss_valid, iss_rd,
    input  exu_valid, exu_rd, exu_wen, exu_data,
    input  lsu_valid, lsu_rd, lsu_wen, lsu_rdata, lsu_size, lsu_unsigned,
    output exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, busy_mask, instret
`ifdef WB_DIFFTEST_EN
    , input  exu_pc, lsu_pc
    , output commit_valid, commit_pc
`endif
  );

endinterface

// File: rtl/wb_scoreboard_load_ext.sv
// rtl/wb_scoreboard_load_ext.sv - load data extender (byte/half/word, sign or zero)
module load_ext
  import wb_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_size)
      LS_B:    o_data = i_unsigned ? {24'h0, i_data[7:0]}  : {{24{i_data[7]}},  i_data[7:0]};
      LS_H:    o_data = i_unsigned ? {16'h0, i_data[15:0]} : {{16{i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - LSU/EXU writeback arbiter, regfile write stage, busy scoreboard
// WB_DIFFTEST_EN adds difftest commit PC tracking.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  wb_scoreboard_if.slave bus
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic                  w_lsu_xfer;
  logic                  w_exu_xfer;
  logic                  w_xfer;
  logic                  w_wen;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [31:0]           w_ext_data;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_rf_wen;
  logic [NREG-1:0]       w_set;
  logic [NREG-1:0]       w_clr;
  logic [NREG-1:0]       w_busy_nxt;

  logic                  r_wb_v;
  logic                  r_rf_wen;
  logic [ADDR_WIDTH-1:0] r_rf_waddr;
  logic [DATA_WIDTH-1:0] r_rf_wdata;
  logic [NREG-1:0]       r_busy;
  logic [63:0]           r_instret;

  // LSU has fixed priority, so exu_ready is purely combinational on lsu_valid.
  assign bus.lsu_ready = 1'b1;
  assign bus.exu_ready = !bus.lsu_valid;
  assign w_lsu_xfer    = bus.lsu_valid;
  assign w_exu_xfer    = bus.exu_valid && !bus.lsu_valid;
  assign w_xfer        = w_lsu_xfer || w_exu_xfer;
  assign w_rd          = w_lsu_xfer ? bus.lsu_rd  : bus.exu_rd;
  assign w_wen         = w_lsu_xfer ? bus.lsu_wen : bus.exu_wen;
  assign w_sel_data    = w_lsu_xfer ? w_ext_data  : bus.exu_data;

  load_ext u_load_ext (
    .i_data     (bus.lsu_rdata),
    .i_size     (bus.lsu_size),
    .i_unsigned (bus.lsu_unsigned),
    .o_data     (w_ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_v     <= WB_RST_V;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= WB_RST_ADDR[ADDR_WIDTH-1:0];
      r_rf_wdata <= WB_RST_DATA;
    end else begin
      r_wb_v   <= w_xfer;
      r_rf_wen <= w_xfer && w_wen && (w_rd != '0);
      if (w_xfer) begin
        r_rf_waddr <= w_rd;
        r_rf_wdata <= w_sel_data;
      end
    end
  end

  assign w_rf_wen     = r_wb_v && r_rf_wen;
  assign bus.rf_wen   = w_rf_wen;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;

  // Clear on the regfile write edge, set on issue; set is applied last so it wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (bus.iss_valid) w_set[bus.iss_rd] = 1'b1;
    if (w_rf_wen)      w_clr[r_rf_waddr] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_instret <= 64'd0;
    end else begin
      r_busy <= w_busy_nxt;
      if (r_wb_v) r_instret <= r_instret + 64'd1;
    end
  end

  assign bus.busy_mask = r_busy;
  assign bus.instret   = r_instret;

`ifdef WB_DIFFTEST_EN
  logic [31:0] r_commit_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_commit_pc <= 32'd0;
    else if (w_xfer) r_commit_pc <= w_lsu_xfer ? bus.lsu_pc : bus.exu_pc;
  end

  assign bus.commit_valid = r_wb_v;
  assign bus.commit_pc    = r_commit_pc;
`endif

endmodule
